// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: PS/2 set-2 scan codes, the four-player keymap and joystick bit-index helpers.
package arcade_input_pkg;

    // Held-key slot order within one player's row of KEYMAP.
    localparam int unsigned K_UP     = 0;
    localparam int unsigned K_DOWN   = 1;
    localparam int unsigned K_LEFT   = 2;
    localparam int unsigned K_RIGHT  = 3;
    localparam int unsigned K_FIRE0  = 4;
    localparam int unsigned K_START0 = 8;
    localparam int unsigned K_START1 = 9;
    localparam int unsigned K_COIN0  = 10;
    localparam int unsigned K_COIN1  = 11;
    localparam int unsigned KEYS     = 12;
    localparam int unsigned KB_FIRES = 4;

    // 8'h00 marks an empty slot; no real key event may ever match it.
    localparam logic [7:0] SC_NONE   = 8'h00;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_3      = 8'h26;
    localparam logic [7:0] SC_4      = 8'h25;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_6      = 8'h36;
    localparam logic [7:0] SC_7      = 8'h3D;
    localparam logic [7:0] SC_8      = 8'h3E;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_B      = 8'h32;
    localparam logic [7:0] SC_C      = 8'h21;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_I      = 8'h43;
    localparam logic [7:0] SC_J      = 8'h3B;
    localparam logic [7:0] SC_K      = 8'h42;
    localparam logic [7:0] SC_L      = 8'h4B;
    localparam logic [7:0] SC_M      = 8'h3A;
    localparam logic [7:0] SC_N      = 8'h31;
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_V      = 8'h2A;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_COMMA  = 8'h41;
    // Numpad 8/2/4/6 share their base codes with the arrows (extended flag is dropped).
    localparam logic [7:0] SC_KP8    = 8'h75;
    localparam logic [7:0] SC_KP2    = 8'h72;
    localparam logic [7:0] SC_KP4    = 8'h6B;
    localparam logic [7:0] SC_KP6    = 8'h74;

    localparam logic [7:0] KEYMAP [4][KEYS] = '{
        '{SC_UP,  SC_DOWN, SC_LEFT, SC_RIGHT, SC_LCTRL, SC_LALT, SC_SPACE, SC_LSHIFT,
          SC_F1,  SC_1,    SC_ESC,  SC_5},
        '{SC_R,   SC_F,    SC_D,    SC_G,     SC_A,     SC_S,    SC_Q,     SC_W,
          SC_F2,  SC_2,    SC_6,    SC_NONE},
        '{SC_I,   SC_K,    SC_J,    SC_L,     SC_Z,     SC_X,    SC_C,     SC_V,
          SC_3,   SC_NONE, SC_7,    SC_NONE},
        '{SC_KP8, SC_KP2,  SC_KP4,  SC_KP6,   SC_B,     SC_N,    SC_M,     SC_COMMA,
          SC_4,   SC_NONE, SC_8,    SC_NONE}
    };

    function automatic int unsigned jb_start(input int unsigned buttons);
        return 4 + buttons;
    endfunction

    function automatic int unsigned jb_coin(input int unsigned buttons);
        return 5 + buttons;
    endfunction

    function automatic int unsigned jb_pause(input int unsigned buttons);
        return 6 + buttons;
    endfunction

endpackage

// File: rtl/arcade_input_map_coin_stretch.sv
// coin_stretch: holds a coin line high for at least HOLD cycles after each rising edge of raw.
module coin_stretch #(
    parameter int unsigned HOLD = 54080
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic out
);
    localparam int unsigned CW = $clog2(64'(HOLD) + 64'd1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw_prev_q, raw_prev_d;
    logic          out_q, out_d;

    always_comb begin
        raw_prev_d = raw;
        cnt_d      = cnt_q;
        if (raw && !raw_prev_q) begin
            cnt_d = CW'(HOLD);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        out_d = raw | (cnt_q != '0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            raw_prev_q <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            raw_prev_q <= raw_prev_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/arcade_input_map.sv
// arcade_input_map: PS/2 held-key decode merged with joystick words, coin stretching and autofire.
// Autofire on fire button 0 is built only when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_map
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS   = 2,
    parameter int unsigned BUTTONS   = 4,
    parameter int unsigned COIN_HOLD = 54080,
    parameter int unsigned AF_PERIOD = 180000
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*PLAYERS-1:0]      joy,
    input  logic                       kbd_clear,
    input  logic [PLAYERS-1:0]         af_enable,
    output logic [PLAYERS-1:0]         o_up,
    output logic [PLAYERS-1:0]         o_down,
    output logic [PLAYERS-1:0]         o_left,
    output logic [PLAYERS-1:0]         o_right,
    output logic [BUTTONS*PLAYERS-1:0] o_fire,
    output logic [PLAYERS-1:0]         o_start,
    output logic [PLAYERS-1:0]         o_coin,
    output logic                       o_pause
);
    localparam int unsigned JB_START = jb_start(BUTTONS);
    localparam int unsigned JB_COIN  = jb_coin(BUTTONS);
    localparam int unsigned JB_PAUSE = jb_pause(BUTTONS);

    logic                            prev_tgl_q, prev_tgl_d;
    logic                            armed_q, armed_d;
    logic                            ps2_event;
    logic [PLAYERS-1:0][KEYS-1:0]    held_q, held_d;

    logic [15:0]                     word;
    logic [PLAYERS-1:0]              raw_up, raw_down, raw_left, raw_right, raw_start, raw_coin;
    logic [BUTTONS*PLAYERS-1:0]      raw_fire;
    logic                            raw_pause;

    logic [PLAYERS-1:0]              up_q, down_q, left_q, right_q, start_q;
    logic [BUTTONS*PLAYERS-1:0]      fire_q, fire_d;
    logic                            pause_q;
    logic                            unused_inputs;

    // armed_q keeps the first post-reset cycle from treating the current toggle level as an event.
    always_comb begin
        prev_tgl_d = ps2_key[10];
        armed_d    = 1'b1;
        ps2_event  = armed_q && (ps2_key[10] != prev_tgl_q);
        held_d     = held_q;
        if (kbd_clear) begin
            held_d = '0;
        end else if (ps2_event) begin
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                for (int unsigned k = 0; k < KEYS; k++) begin
                    if (KEYMAP[p][k] != SC_NONE && KEYMAP[p][k] == ps2_key[7:0]) begin
                        held_d[p][k] = ps2_key[9];
                    end
                end
            end
        end
    end

    always_comb begin
        word      = '0;
        raw_up    = '0;
        raw_down  = '0;
        raw_left  = '0;
        raw_right = '0;
        raw_start = '0;
        raw_coin  = '0;
        raw_fire  = '0;
        raw_pause = 1'b0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            word         = joy[16*p +: 16];
            raw_right[p] = word[0] | held_q[p][K_RIGHT];
            raw_left[p]  = word[1] | held_q[p][K_LEFT];
            raw_down[p]  = word[2] | held_q[p][K_DOWN];
            raw_up[p]    = word[3] | held_q[p][K_UP];
            for (int unsigned b = 0; b < BUTTONS; b++) begin
                raw_fire[BUTTONS*p + b] = word[4 + b] |
                                          ((b < KB_FIRES) ? held_q[p][K_FIRE0 + b] : 1'b0);
            end
            raw_start[p] = word[JB_START] | held_q[p][K_START0] | held_q[p][K_START1];
            raw_coin[p]  = word[JB_COIN] | held_q[p][K_COIN0] | held_q[p][K_COIN1];
            raw_pause    = raw_pause | word[JB_PAUSE];
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int unsigned AFW = $clog2(AF_PERIOD);

    logic [AFW-1:0] af_cnt_q, af_cnt_d;
    logic           af_phase_q, af_phase_d;

    always_comb begin
        af_cnt_d   = af_cnt_q + AFW'(1);
        af_phase_d = af_phase_q;
        if (af_cnt_q == AFW'(AF_PERIOD - 1)) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
        end
        fire_d = raw_fire;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (af_enable[p]) begin
                fire_d[BUTTONS*p] = raw_fire[BUTTONS*p] & af_phase_q;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end

    assign unused_inputs = ^{ps2_key[8], joy};
`else
    always_comb begin
        fire_d = raw_fire;
    end

    assign unused_inputs = ^{ps2_key[8], joy, af_enable};
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_tgl_q <= 1'b0;
            armed_q    <= 1'b0;
            held_q     <= '0;
            up_q       <= '0;
            down_q     <= '0;
            left_q     <= '0;
            right_q    <= '0;
            start_q    <= '0;
            fire_q     <= '0;
            pause_q    <= 1'b0;
        end else begin
            prev_tgl_q <= prev_tgl_d;
            armed_q    <= armed_d;
            held_q     <= held_d;
            up_q       <= raw_up;
            down_q     <= raw_down;
            left_q     <= raw_left;
            right_q    <= raw_right;
            start_q    <= raw_start;
            fire_q     <= fire_d;
            pause_q    <= raw_pause;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        coin_stretch #(
            .HOLD(COIN_HOLD)
        ) u_coin (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .raw    (raw_coin[p]),
            .out    (o_coin[p])
        );
    end

    assign o_up    = up_q;
    assign o_down  = down_q;
    assign o_left  = left_q;
    assign o_right = right_q;
    assign o_fire  = fire_q;
    assign o_start = start_q;
    assign o_pause = pause_q;

endmodule

// File: doc/arcade_input_map.md
# arcade_input_map

Parametrised player-input front end for arcade cores, sitting between `hps_io` (joystick words, `ps2_key`) and the game-specific input-port packing. It handles the following for up to four players:

- decodes PS/2 key events into held-key state;
- merges held keys with the joystick buttons;
- stretches coin pulses to a guaranteed minimum width;
- optionally gates fire button 0 through an autofire oscillator.

All outputs are active-high. Game-specific inversion and bit packing happen downstream.

## Interface
Parameters:
- `PLAYERS`, 2: number of players, 1..4.
- `BUTTONS`, 4: fire buttons per player, 1..6.
- `COIN_HOLD`, 54080: minimum coin-high width in `clk_sys` cycles (5 ms at 10.816 MHz); must be ≥1.
- `AF_PERIOD`, 180000: autofire half-period in cycles; must be ≥2.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  [10] event toggle, [9] pressed, [7:0] scan code. [8] (extended flag) is ignored.
- `joy`  in  16*PLAYERS  joystick words, player p at [16p+15:16p].
- `kbd_clear`  in  1  synchronous clear of all held-key state (tie to `ioctl_download`).
- `af_enable`  in  PLAYERS  per-player autofire request.
- `o_up`, `o_down`, `o_left`, `o_right`  out  PLAYERS  directions.
- `o_fire`  out  BUTTONS*PLAYERS  fire buttons, player p at [BUTTONS*p +: BUTTONS].
- `o_start`  out  PLAYERS  start buttons.
- `o_coin`  out  PLAYERS  stretched coin.
- `o_pause`  out  1  OR of all players' pause bits.

## Operation
Joystick bit layout per player word:
- 0 R, 1 L, 2 D, 3 U;
- 4..3+BUTTONS fire;
- 4+BUTTONS start;
- 5+BUTTONS coin;
- 6+BUTTONS pause;
- higher bits ignored.

PS/2 decode:
- `prev_tgl` register; an event is `ps2_key[10] != prev_tgl`.
- The first cycle after reset release only loads `prev_tgl` and processes no event.
- On an event, `ps2_key[9]` is written to every held-key bit whose keymap code equals `ps2_key[7:0]`. Unmapped codes are ignored.
- Keymap (package table):
  - P1: arrows; LCtrl/LAlt/Space/LShift fire 0..3; F1 or 1 start; Esc or 5 coin.
  - P2: R/F/D/G; A/S/Q/W; F2 or 2; 6.
  - P3: I/K/J/L; Z/X/C/V; 3; 7.
  - P4: numpad 8/2/4/6; B/N/M/comma; 4; 8.
  - Fire keys beyond index 3 are joystick-only.
- `kbd_clear` zeroes all held keys. It wins over a same-cycle event; `prev_tgl` still updates.

Merge: `raw = joy bit | held key`.

Coin stretcher, per player:
- 32-bit-safe counter of width `$clog2(COIN_HOLD+1)`.
- A rising edge of raw coin loads `COIN_HOLD`; otherwise the counter decrements while nonzero.
- A retrigger mid-count reloads the counter.
- `o_coin = raw_coin | (cnt != 0)`.

Autofire: see Configuration.

## Timing
- All outputs are registered and reset to 0. All counters and held keys reset to 0.
- Latency:
  - `joy` to outputs: 1 cycle.
  - PS/2 event to outputs: 2 cycles (held-key register, then output register).
- Coin:
  - A 1-cycle raw pulse gives `o_coin` high for exactly `COIN_HOLD`+1 cycles.
  - A raw coin held longer than `COIN_HOLD` keeps `o_coin` high until 1 cycle after raw falls, plus the residual count from the last edge.
- Autofire phase:
  - Free-running counter over 0..AF_PERIOD-1.
  - `af_phase` toggles on wrap, so the square wave has period 2·AF_PERIOD.
- Asserting `reset_n` mid-stretch or mid-event clears everything immediately. No event is replayed after release.

## Configuration
`ARCADE_INPUT_AUTOFIRE_EN`:
- Defined: when `af_enable[p]`, `o_fire[p][0] = raw_fire0 & af_phase`. The phase counter is shared by all players. The other buttons are unaffected.
- Undefined: the phase counter is absent, `af_enable` is ignored, and fire passes straight through.

## Structure
- Package `arcade_input_pkg` holds:
  - the scan-code localparams;
  - the `KEYMAP[4][KEYS]` table;
  - functions `jb_start(BUTTONS)`, `jb_coin`, `jb_pause` giving joystick bit indices.
- Sub-module `coin_stretch` (params `HOLD`; ports `clk_sys`, `reset_n`, `raw`, `out`) is instantiated once per player.

## Test plan
- Reset release with `ps2_key[10]=1`: no event is processed and all outputs stay 0. A toggle with pressed=1 and code 0x14 gives `o_fire[0]=1` two cycles later.
- PLAYERS=2, `joy[16+3]=1`: `o_up=2'b10` after 1 cycle. Key 0x2D press and release with joy idle: `o_up[1]` pulses for the interval between events.
- 1-cycle coin pulse on P1 with COIN_HOLD=10: `o_coin[0]` is high for exactly 11 cycles. A retrigger at cycle 5 extends the total to 16.
- `kbd_clear` in the same cycle as a press event for 0x75: `o_up[0]` stays 0, and the next toggle is detected correctly.
- Macro defined, AF_PERIOD=4, `af_enable=1`, fire0 held: `o_fire[0]` is a square wave, 4 cycles high and 4 cycles low. Fire1 is steady.
- BUTTONS=6: `joy` bit 12 sets `o_pause`. Bit 10 sets `o_start`, and bit 11 stretches the coin.
